apb_uart_stream_master: RTL

- APB master that sits directly upstream of apb_uart and drives its register map.
- Runs a five-write configuration sequence on request, then moves bytes between valid/ready streams and the UART: TX stream into TBR, RBR into RX stream.
- Uses the UART's tx_fifo_full and rx_fifo_empty status outputs for flow control.
- Replaces software polling loops on the SoC side.

---
 rtl/apb_uart_pkg.sv | 45 ++++
 rtl/apb_master_if.sv | 80 ++++++++
 rtl/apb_uart_stream_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_pkg.sv
// rtl/apb_uart_pkg.sv - shared constants and types for the APB UART stream master
package apb_uart_pkg;

    // Default UART register map (byte-wide registers, word-indexed addresses).
    localparam logic [31:0] MDR_ADDR_DEF = 32'd0;
    localparam logic [31:0] DLL_ADDR_DEF = 32'd1;
    localparam logic [31:0] DLH_ADDR_DEF = 32'd2;
    localparam logic [31:0] LCR_ADDR_DEF = 32'd3;
    localparam logic [31:0] TBR_ADDR_DEF = 32'd6;
    localparam logic [31:0] RBR_ADDR_DEF = 32'd7;

    // Baud-generator enable position inside LCR.
    localparam int BGE_BIT_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_LCR0,
        S_CFG_MDR,
        S_CFG_DLH,
        S_CFG_DLL,
        S_CFG_LCR1,
        S_RD,
        S_WR
    } seq_state_e;

    // PH_IDLE is the resting phase when nothing has been issued since reset
    // or since the last GAP.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS,
        PH_GAP
    } apb_phase_e;

    // LCR value with the baud-generator enable bit forced to bge.
    function automatic logic [7:0] lcr_with_bge(input logic [7:0] lcr,
                                                input int         pos,
                                                input logic       bge);
        logic [7:0] v;
        v      = lcr;
        v[pos] = bge;
        return v;
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - single-transfer APB master phase engine (SETUP/ACCESS/GAP)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req                     issue a transfer (taken only while ready=1)
//   addr, wdata, write      transfer attributes, latched on an accepted req
//   ready                   engine can accept req this cycle (IDLE or GAP)
//   done                    completing ACCESS cycle (PREADY=1)
//   rdata, slverr           read byte and error flag, valid with done
//   PSEL..PRDATA            APB master bus
module apb_master_if
    import apb_uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [7:0]  wdata,
    input  logic        write,
    output logic        ready,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        slverr,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [7:0]  PRDATA
);

    apb_phase_e  phase_q, phase_d;
    logic [31:0] paddr_q;
    logic [7:0]  pwdata_q;
    logic        pwrite_q;

    // A new transfer may start straight out of GAP, so back-to-back
    // transfers cost exactly three cycles each.
    assign ready = (phase_q == PH_IDLE) || (phase_q == PH_GAP);

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE,
            PH_GAP:    phase_d = req ? PH_SETUP : PH_IDLE;
            PH_SETUP:  phase_d = PH_ACCESS;
            PH_ACCESS: phase_d = PREADY ? PH_GAP : PH_ACCESS;
            default:   phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (req && ready) begin
                paddr_q  <= addr;
                pwdata_q <= wdata;
                pwrite_q <= write;
            end
        end
    end

    assign PSEL    = (phase_q == PH_SETUP) || (phase_q == PH_ACCESS);
    assign PENABLE = (phase_q == PH_ACCESS);
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = {24'h0, pwdata_q};

    assign done   = (phase_q == PH_ACCESS) && PREADY;
    assign rdata  = PRDATA;
    assign slverr = PSLVERR;

endmodule

// File: rtl/apb_uart_stream_master.sv
// rtl/apb_uart_stream_master.sv - APB master bridging byte streams and config to apb_uart
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cfg_start, cfg_mdr/divisor/lcr      configuration request and values
//   cfg_busy, cfg_done                  configuration status
//   s_valid/s_ready/s_data              TX byte stream in  (written to TBR)
//   m_valid/m_ready/m_data              RX byte stream out (read from RBR)
//   PSEL..PRDATA                        APB master bus to the UART
//   tx_fifo_full, rx_fifo_empty         UART FIFO status for flow control
//   err_o                               sticky PSLVERR indication
module apb_uart_stream_master
    import apb_uart_pkg::*;
#(
    parameter logic [31:0] MDR_ADDR = MDR_ADDR_DEF,
    parameter logic [31:0] DLL_ADDR = DLL_ADDR_DEF,
    parameter logic [31:0] DLH_ADDR = DLH_ADDR_DEF,
    parameter logic [31:0] LCR_ADDR = LCR_ADDR_DEF,
    parameter logic [31:0] TBR_ADDR = TBR_ADDR_DEF,
    parameter logic [31:0] RBR_ADDR = RBR_ADDR_DEF,
    parameter int          BGE_BIT  = BGE_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [7:0]  cfg_mdr,
    input  logic [15:0] cfg_divisor,
    input  logic [7:0]  cfg_lcr,
    output logic        cfg_busy,
    output logic        cfg_done,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [31:0] PRDATA,
    input  logic        tx_fifo_full,
    input  logic        rx_fifo_empty,
    output logic        err_o
);

    seq_state_e  state_q, state_d;
    logic        run_q;
    logic        cfg_busy_q;
    logic        cfg_done_q;
    logic [2:0]  cfg_idx_q;
    logic [7:0]  cfg_mdr_q;
    logic [15:0] cfg_div_q;
    logic [7:0]  cfg_lcr_q;
    logic        m_valid_q;
    logic [7:0]  m_data_q;
    logic        err_q;

    logic        if_req;
    logic [31:0] if_addr;
    logic [7:0]  if_wdata;
    logic        if_write;
    logic        if_ready;
    logic        if_done;
    logic [7:0]  if_rdata;
    logic        if_slverr;
    logic        in_cfg;

    // Only the low byte of the UART read data is meaningful.
    logic unused_prdata;
    assign unused_prdata = ^PRDATA[31:8];

    assign in_cfg = (state_q == S_CFG_LCR0) || (state_q == S_CFG_MDR) ||
                    (state_q == S_CFG_DLH)  || (state_q == S_CFG_DLL) ||
                    (state_q == S_CFG_LCR1);

    // Issue arbiter. run_q keeps s_ready low throughout reset and the first
    // cycle after it. A stream read is never picked while cfg_busy_q because
    // configuration always wins in IDLE.
    always_comb begin
        state_d  = state_q;
        if_req   = 1'b0;
        if_addr  = '0;
        if_wdata = '0;
        if_write = 1'b0;
        s_ready  = 1'b0;
        if (run_q && (state_q == S_IDLE) && if_ready) begin
            if (cfg_busy_q) begin
                if_req   = 1'b1;
                if_write = 1'b1;
                case (cfg_idx_q)
                    3'd0: begin
                        if_addr  = LCR_ADDR;
                        if_wdata = lcr_with_bge(cfg_lcr_q, BGE_BIT, 1'b0);
                        state_d  = S_CFG_LCR0;
                    end
                    3'd1: begin
                        if_addr  = MDR_ADDR;
                        if_wdata = cfg_mdr_q;
                        state_d  = S_CFG_MDR;
                    end
                    3'd2: begin
                        if_addr  = DLH_ADDR;
                        if_wdata = cfg_div_q[15:8];
                        state_d  = S_CFG_DLH;
                    end
                    3'd3: begin
                        if_addr  = DLL_ADDR;
                        if_wdata = cfg_div_q[7:0];
                        state_d  = S_CFG_DLL;
                    end
                    default: begin
                        if_addr  = LCR_ADDR;
                        if_wdata = lcr_with_bge(cfg_lcr_q, BGE_BIT, 1'b1);
                        state_d  = S_CFG_LCR1;
                    end
                endcase
            end else if (!rx_fifo_empty && !m_valid_q) begin
                if_req  = 1'b1;
                if_addr = RBR_ADDR;
                state_d = S_RD;
            end else if (s_valid && !tx_fifo_full) begin
                if_req   = 1'b1;
                if_write = 1'b1;
                if_addr  = TBR_ADDR;
                if_wdata = s_data;
                s_ready  = 1'b1;
                state_d  = S_WR;
            end
        end else if ((state_q != S_IDLE) && if_done) begin
            // Back to IDLE for the GAP cycle, where the next decision is made.
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            run_q      <= 1'b0;
            cfg_busy_q <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_idx_q  <= '0;
            cfg_mdr_q  <= '0;
            cfg_div_q  <= '0;
            cfg_lcr_q  <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            cfg_done_q <= 1'b0;

            if (!cfg_busy_q && cfg_start) begin
                cfg_busy_q <= 1'b1;
                cfg_idx_q  <= '0;
                cfg_mdr_q  <= cfg_mdr;
                cfg_div_q  <= cfg_divisor;
                cfg_lcr_q  <= cfg_lcr;
            end else if (cfg_busy_q && in_cfg && if_done) begin
                // Errored config writes still advance the sequence.
                if (cfg_idx_q == 3'd4) begin
                    cfg_busy_q <= 1'b0;
                    cfg_done_q <= 1'b1;
                end else begin
                    cfg_idx_q <= cfg_idx_q + 3'd1;
                end
            end

            if ((state_q == S_RD) && if_done) begin
                m_valid_q <= 1'b1;
                m_data_q  <= if_rdata;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end

            if (if_done && if_slverr) begin
                err_q <= 1'b1;
            end
        end
    end

    apb_master_if u_apb_master_if (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (if_req),
        .addr    (if_addr),
        .wdata   (if_wdata),
        .write   (if_write),
        .ready   (if_ready),
        .done    (if_done),
        .rdata   (if_rdata),
        .slverr  (if_slverr),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PRDATA  (PRDATA[7:0])
    );

    assign cfg_busy = cfg_busy_q;
    assign cfg_done = cfg_done_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign err_o    = err_q;

endmodule
